// File: rtl/chacha20_poly1305_bus_master.sv
// chacha20_poly1305_bus_master
//
// Bus initiator for the chacha20_poly1305_bus register interface. One host
// command carries one message block. The master writes the key and nonce
// when needed, writes the data, pulses INIT and NEXT, and polls STATUS
// VALID. It then reads the data, polls STATUS TAG, reads the tag and writes
// DONE. Finally it hands the ciphertext and tag back on the result port.
//
// Ports
//   clk, reset_n          : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   : host command handshake
//   cmd_rekey             : force key/nonce writes for this block
//   cmd_key, cmd_nonce    : key (word 0 in MSBs) and nonce (word 0 in MSBs)
//   cmd_block             : 512-bit plaintext block
//   rsp_valid/rsp_ready   : result handshake; result held until accepted
//   rsp_block, rsp_tag    : data read from 0x30, low 128 bits read from 0x40
//   rsp_error             : a status poll ran out of attempts
//   cs, we, address       : bus strobe, write enable, register address
//   write_data, read_data : bus data
//
// Every bus transaction is a one-cycle cs pulse. At least one cs-low cycle
// follows each pulse. Read data is captured at the end of the cycle after
// the cs pulse. All outputs come straight from flops.

module chacha20_poly1305_bus_master #(
  parameter int TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_rekey,
  input  logic [255:0] cmd_key,
  input  logic [95:0]  cmd_nonce,
  input  logic [511:0] cmd_block,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [511:0] rsp_block,
  output logic [127:0] rsp_tag,
  output logic         rsp_error,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [511:0] write_data,
  input  logic [511:0] read_data
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_NONCE  = 8'h20;
  localparam logic [7:0] ADDR_DATA   = 8'h30;
  localparam logic [7:0] ADDR_TAG    = 8'h40;

  typedef enum logic [3:0] {
    IDLE,
    WR_KEY,
    WR_NONCE,
    WR_DATA,
    WR_INIT,
    WR_NEXT,
    POLL_VALID,
    RD_DATA,
    POLL_TAG,
    RD_TAG,
    WR_DONE,
    RESP
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     sub_q, sub_d;
  logic [2:0]     idx_q, idx_d;
  logic [CW-1:0]  poll_cnt_q, poll_cnt_d;
  logic           key_loaded_q, key_loaded_d;
  logic [255:0]   key_q, key_d;
  logic [95:0]    nonce_q, nonce_d;
  logic [511:0]   block_q, block_d;
  logic           cs_q, cs_d;
  logic           we_q, we_d;
  logic [7:0]     address_q, address_d;
  logic [511:0]   write_data_q, write_data_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_error_q, rsp_error_d;
  logic [511:0]   rsp_block_q, rsp_block_d;
  logic [127:0]   rsp_tag_q, rsp_tag_d;

  // Transaction descriptor for the current state
  logic [7:0]     txn_addr;
  logic [511:0]   txn_wdata;
  logic           txn_we;
  logic [31:0]    nonce_word;
  logic           poll_bit;

  function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] i);
    key_word = k[32*(7-i) +: 32];
  endfunction

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_block  = rsp_block_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_error  = rsp_error_q;
  assign cs         = cs_q;
  assign we         = we_q;
  assign address    = address_q;
  assign write_data = write_data_q;

  // What each bus state puts on the bus when it issues its cs pulse.
  always_comb begin
    txn_addr  = 8'h00;
    txn_wdata = '0;
    txn_we    = 1'b0;
    case (idx_q[1:0])
      2'd0:    nonce_word = nonce_q[95:64];
      2'd1:    nonce_word = nonce_q[63:32];
      default: nonce_word = nonce_q[31:0];
    endcase
    case (state_q)
      WR_KEY: begin
        txn_addr  = ADDR_KEY + {5'd0, idx_q};
        txn_wdata = {480'h0, key_word(key_q, idx_q)};
        txn_we    = 1'b1;
      end
      WR_NONCE: begin
        txn_addr  = ADDR_NONCE + {5'd0, idx_q};
        txn_wdata = {480'h0, nonce_word};
        txn_we    = 1'b1;
      end
      WR_DATA: begin
        txn_addr  = ADDR_DATA;
        txn_wdata = block_q;
        txn_we    = 1'b1;
      end
      WR_INIT: begin
        txn_addr  = ADDR_CTRL;
        txn_wdata = 512'h1;
        txn_we    = 1'b1;
      end
      WR_NEXT: begin
        txn_addr  = ADDR_CTRL;
        txn_wdata = 512'h2;
        txn_we    = 1'b1;
      end
      WR_DONE: begin
        txn_addr  = ADDR_CTRL;
        txn_wdata = 512'h4;
        txn_we    = 1'b1;
      end
      POLL_VALID, POLL_TAG: txn_addr = ADDR_STATUS;
      RD_DATA:              txn_addr = ADDR_DATA;
      RD_TAG:               txn_addr = ADDR_TAG;
      default: ;
    endcase
  end

  // Sequencer. sub_q tracks the phase inside a transaction:
  // 0 = issue the cs pulse (this is also the gap after the previous pulse),
  // 1 = cs cycle, 2 = read capture cycle (read states only).
  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    idx_d        = idx_q;
    poll_cnt_d   = poll_cnt_q;
    key_loaded_d = key_loaded_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    block_d      = block_q;
    cs_d         = 1'b0;
    we_d         = 1'b0;
    address_d    = address_q;
    write_data_d = write_data_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_error_d  = rsp_error_q;
    rsp_block_d  = rsp_block_q;
    rsp_tag_d    = rsp_tag_q;
    poll_bit     = (state_q == POLL_VALID) ? read_data[1] : read_data[2];

    if (state_q != IDLE && state_q != RESP && sub_q == 2'd0) begin
      cs_d         = 1'b1;
      we_d         = txn_we;
      address_d    = txn_addr;
      write_data_d = txn_wdata;
      sub_d        = 2'd1;
    end

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          key_d       = cmd_key;
          nonce_d     = cmd_nonce;
          block_d     = cmd_block;
          rsp_error_d = 1'b0;
          rsp_block_d = '0;
          rsp_tag_d   = '0;
          idx_d       = 3'd0;
          sub_d       = 2'd0;
          state_d     = (cmd_rekey || !key_loaded_q) ? WR_KEY : WR_DATA;
        end
      end
      WR_KEY: begin
        if (sub_q == 2'd1) begin
          sub_d = 2'd0;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = WR_NONCE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      WR_NONCE: begin
        if (sub_q == 2'd1) begin
          sub_d = 2'd0;
          if (idx_q == 3'd2) begin
            idx_d        = 3'd0;
            key_loaded_d = 1'b1;
            state_d      = WR_DATA;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      WR_DATA: if (sub_q == 2'd1) begin sub_d = 2'd0; state_d = WR_INIT; end
      WR_INIT: if (sub_q == 2'd1) begin sub_d = 2'd0; state_d = WR_NEXT; end
      WR_NEXT: begin
        if (sub_q == 2'd1) begin
          sub_d      = 2'd0;
          poll_cnt_d = '0;
          state_d    = POLL_VALID;
        end
      end
      POLL_VALID, POLL_TAG: begin
        if (sub_q == 2'd1) begin
          sub_d = 2'd2;
        end else if (sub_q == 2'd2) begin
          sub_d = 2'd0;
          if (poll_bit) begin
            state_d = (state_q == POLL_VALID) ? RD_DATA : RD_TAG;
          end else if (poll_cnt_q == POLL_LAST) begin
            // Out of attempts: skip the remaining reads and close the job.
            rsp_error_d = 1'b1;
            state_d     = WR_DONE;
          end else begin
            poll_cnt_d = poll_cnt_q + CW'(1);
          end
        end
      end
      RD_DATA: begin
        if (sub_q == 2'd1) begin
          sub_d = 2'd2;
        end else if (sub_q == 2'd2) begin
          sub_d       = 2'd0;
          rsp_block_d = read_data;
          poll_cnt_d  = '0;
          state_d     = POLL_TAG;
        end
      end
      RD_TAG: begin
        if (sub_q == 2'd1) begin
          sub_d = 2'd2;
        end else if (sub_q == 2'd2) begin
          sub_d     = 2'd0;
          rsp_tag_d = read_data[127:0];
          state_d   = WR_DONE;
        end
      end
      WR_DONE: begin
        if (sub_q == 2'd1) begin
          sub_d       = 2'd0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops cs immediately and forgets the key.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sub_q        <= 2'd0;
      idx_q        <= 3'd0;
      poll_cnt_q   <= '0;
      key_loaded_q <= 1'b0;
      key_q        <= '0;
      nonce_q      <= '0;
      block_q      <= '0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      address_q    <= 8'h00;
      write_data_q <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_block_q  <= '0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      idx_q        <= idx_d;
      poll_cnt_q   <= poll_cnt_d;
      key_loaded_q <= key_loaded_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      block_q      <= block_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_error_q  <= rsp_error_d;
      rsp_block_q  <= rsp_block_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

endmodule
